netdelay_multi: RTL

- Synthesizable, clocked, multi-channel successor to the inverting rise/fall net-delay element.
- Each channel drives its output to the (optionally inverted) input after a programmable number of clock cycles.
- Rise and fall delays are set independently.
- Inertial filtering: input pulses shorter than the applicable delay are rejected and flagged.
- Used wherever gate/net delay behaviour must be modelled in cycle-accurate RTL rather than with `#` delays.

---
 rtl/netdelay_multi.sv | 112 +++++++++++
 1 files changed

// File: rtl/netdelay_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : netdelay_multi
// Description : Multi-channel clocked net-delay element with independent
//               rise/fall delays and inertial (pulse-rejecting) filtering.
//               Each channel follows its (optionally inverted) input after
//               a programmable number of clock cycles. A target that does
//               not stay stable for the full applicable delay is discarded
//               and flagged with a one-cycle glitch pulse.
//
// Parameters  : N_CH   - number of independent channels
//               DW     - width of the delay configuration ports
//               INVERT - 1: channel target is ~x (inverter), 0: x (buffer)
//               RST_Y  - value loaded into every y bit on reset
//
// Ports       : clk      in   system clock, rising edge active
//               rst      in   asynchronous active-high reset
//               x        in   [N_CH] channel inputs, synchronous to clk
//               rise_dly in   [DW]   cycles for a 0->1 output transition
//               fall_dly in   [DW]   cycles for a 1->0 output transition
//               y        out  [N_CH] delayed channel outputs (registered)
//               busy     out  [N_CH] channel target differs from y (comb)
//               glitch   out  [N_CH] one-cycle pulse on a cancelled
//                                    pending transition (registered)
//
// Revision    : 1.0 - initial release
// ============================================================================
module netdelay_multi #(
    parameter int N_CH   = 8,
    parameter int DW     = 4,
    parameter bit INVERT = 1'b1,
    parameter bit RST_Y  = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] x,
    input  logic [DW-1:0]   rise_dly,
    input  logic [DW-1:0]   fall_dly,
    output logic [N_CH-1:0] y,
    output logic [N_CH-1:0] busy,
    output logic [N_CH-1:0] glitch
);

    localparam logic [DW-1:0] c_dly_one = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW:0]   c_inc     = {{DW{1'b0}}, 1'b1};

    // A programmed delay of zero behaves exactly like a delay of one: the
    // output follows at the first edge that sees the new target. Folding
    // this once here keeps the per-channel compare simple.
    logic [DW-1:0] w_rise_eff;
    logic [DW-1:0] w_fall_eff;

    assign w_rise_eff = (rise_dly == '0) ? c_dly_one : rise_dly;
    assign w_fall_eff = (fall_dly == '0) ? c_dly_one : fall_dly;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi = gi + 1) begin : g_ch
            logic          r_y;
            logic          r_glitch;
            // Number of consecutive edges the target has already differed
            // from y without being committed. Never exceeds 2^DW-2 because
            // the commit fires once cnt+1 reaches the delay (max 2^DW-1).
            logic [DW-1:0] r_cnt;

            logic          w_tgt;
            logic [DW-1:0] w_dly;
            logic [DW:0]   w_cnt_inc;
            logic          w_mismatch;
            logic          w_done;

            assign w_tgt      = x[gi] ^ INVERT;
            // Delay is selected by the direction the output would move in,
            // which is given by the target value itself.
            assign w_dly      = w_tgt ? w_rise_eff : w_fall_eff;
            // One extra bit so the compare cannot wrap at the top count.
            assign w_cnt_inc  = {1'b0, r_cnt} + c_inc;
            // The current edge counts as one of the D stable edges, so the
            // transition commits when cnt+1 >= D. Re-evaluating against the
            // live delay lets a shrunk delay commit immediately.
            assign w_done     = (w_cnt_inc >= {1'b0, w_dly});
            assign w_mismatch = (w_tgt != r_y);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_y      <= RST_Y;
                    r_cnt    <= '0;
                    r_glitch <= 1'b0;
                end else if (!w_mismatch) begin
                    // Target fell back to the current output. If something
                    // was pending, that pulse was too short: drop it and flag.
                    r_cnt    <= '0;
                    r_glitch <= (r_cnt != '0);
                end else if (w_done) begin
                    r_y      <= w_tgt;
                    r_cnt    <= '0;
                    r_glitch <= 1'b0;
                end else begin
                    r_cnt    <= w_cnt_inc[DW-1:0];
                    r_glitch <= 1'b0;
                end
            end

            assign y[gi]      = r_y;
            assign glitch[gi] = r_glitch;
            assign busy[gi]   = w_mismatch;
        end
    endgenerate

endmodule
`default_nettype wire
